// File: rtl/h_bridge_burst.sv
// rtl/h_bridge_burst.sv - transducer transmit burst generator driving a full H-bridge
//
// Purpose:
//   Produces n_cycles full-bridge square-wave cycles. Each half-wave lasts
//   max(half_period,1) clocks. An all-off dead interval separates every change of
//   drive phase. An optional low-side brake follows the burst. A start/busy/done
//   handshake is provided for the register block. Configuration is captured when
//   start is accepted, so later changes to the config inputs do not affect a burst
//   that is already running.
//
//   Optional build macro HB_ILIMIT_EN:
//     Adds the ilim input. ilim high during a burst aborts it and sets the sticky
//     fault flag, which then blocks start until reset. Without the macro, fault is
//     tied 0.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-low
//   start         1-cycle pulse, begins a burst when idle
//   abort         stops a running burst; all gates go off on the next cycle
//   ilim          overcurrent input (HB_ILIMIT_EN builds only)
//   half_period   drive cycles per half-wave (0 treated as 1)
//   dead          all-off cycles between drive phases (0 = none)
//   n_cycles      full cycles per burst (0 = no drive)
//   brake_len     low-side brake cycles after the burst (0 = none)
//   hlh/hll       left-leg high/low gate drives (registered)
//   hrh/hrl       right-leg high/low gate drives (registered)
//   txrx          1 while transmitting
//   busy          burst in progress
//   done          1-cycle pulse on normal completion
//   fault         sticky overcurrent flag
module h_bridge_burst #(
   parameter int CNT_W  = 16,
   parameter int CYC_W  = 8,
   parameter int DEAD_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
`ifdef HB_ILIMIT_EN
   input  logic              ilim,
`endif
   input  logic [CNT_W-1:0]  half_period,
   input  logic [DEAD_W-1:0] dead,
   input  logic [CYC_W-1:0]  n_cycles,
   input  logic [CNT_W-1:0]  brake_len,
   output logic              hlh,
   output logic              hll,
   output logic              hrh,
   output logic              hrl,
   output logic              txrx,
   output logic              busy,
   output logic              done,
   output logic              fault
);

   typedef enum logic [2:0] {
      S_IDLE, S_DEAD, S_DRV_A, S_DRV_B, S_BRAKE, S_DONE
   } state_t;

   // Phase that follows the current dead interval.
   typedef enum logic [1:0] {T_A, T_B, T_BRAKE} tgt_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

   state_t              state, state_n;
   tgt_t                tgt, tgt_n, enter_tgt, go_tgt;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [CYC_W-1:0]    cyc, cyc_n;
   logic [CNT_W-1:0]    half_q, brake_q;
   logic [DEAD_W-1:0]   dead_q;
   logic                load_cfg, do_enter, do_go;
   logic                active, active_n;
   logic                abort_eff, start_ok;
   logic [CNT_W-1:0]    drv_last, drv_last_in;

   // Counters hold the remaining cycles minus one, so a duration of 1 loads 0.
   assign drv_last    = (half_q == '0)      ? '0 : half_q - CNT_ONE;
   assign drv_last_in = (half_period == '0) ? '0 : half_period - CNT_ONE;

   assign active = (state == S_DEAD) || (state == S_DRV_A) ||
                   (state == S_DRV_B) || (state == S_BRAKE);

`ifdef HB_ILIMIT_EN
   logic fault_q;

   assign abort_eff = abort | ilim;
   assign start_ok  = ~fault_q;
   assign fault     = fault_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fault_q <= 1'b0;
      else if (ilim && active)
         fault_q <= 1'b1;
   end
`else
   assign abort_eff = abort;
   assign start_ok  = 1'b1;
   assign fault     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         tgt     <= T_A;
         cnt     <= '0;
         cyc     <= '0;
         half_q  <= '0;
         dead_q  <= '0;
         brake_q <= '0;
      end else begin
         state <= state_n;
         tgt   <= tgt_n;
         cnt   <= cnt_n;
         cyc   <= cyc_n;
         if (load_cfg) begin
            half_q  <= half_period;
            dead_q  <= dead;
            brake_q <= brake_len;
         end
      end
   end

   always_comb begin
      state_n   = state;
      tgt_n     = tgt;
      cnt_n     = cnt;
      cyc_n     = cyc;
      load_cfg  = 1'b0;
      do_enter  = 1'b0;
      enter_tgt = T_A;
      do_go     = 1'b0;
      go_tgt    = T_A;

      case (state)
         S_IDLE: begin
            // Abort wins over a simultaneous start.
            if (start && !abort && start_ok) begin
               load_cfg = 1'b1;
               cyc_n    = n_cycles;
               if (n_cycles == '0) begin
                  state_n = S_DONE;
               end else if (dead != '0) begin
                  state_n = S_DEAD;
                  cnt_n   = CNT_W'(dead) - CNT_ONE;
                  tgt_n   = T_A;
               end else begin
                  state_n = S_DRV_A;
                  cnt_n   = drv_last_in;
               end
            end
         end
         S_DEAD: begin
            if (cnt != '0) begin
               cnt_n = cnt - CNT_ONE;
            end else begin
               do_go  = 1'b1;
               go_tgt = tgt;
            end
         end
         S_DRV_A: begin
            if (cnt != '0) begin
               cnt_n = cnt - CNT_ONE;
            end else begin
               do_enter  = 1'b1;
               enter_tgt = T_B;
            end
         end
         S_DRV_B: begin
            if (cnt != '0) begin
               cnt_n = cnt - CNT_ONE;
            end else begin
               do_enter  = 1'b1;
               cyc_n     = cyc - CYC_ONE;
               enter_tgt = (cyc > CYC_ONE) ? T_A : T_BRAKE;
            end
         end
         S_BRAKE: begin
            if (cnt != '0)
               cnt_n = cnt - CNT_ONE;
            else
               state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // Every phase change passes through a dead interval unless dead is 0.
      if (do_enter) begin
         if (dead_q != '0) begin
            state_n = S_DEAD;
            cnt_n   = CNT_W'(dead_q) - CNT_ONE;
            tgt_n   = enter_tgt;
         end else begin
            do_go  = 1'b1;
            go_tgt = enter_tgt;
         end
      end

      if (do_go) begin
         case (go_tgt)
            T_A: begin
               state_n = S_DRV_A;
               cnt_n   = drv_last;
            end
            T_B: begin
               state_n = S_DRV_B;
               cnt_n   = drv_last;
            end
            default: begin
               if (brake_q != '0) begin
                  state_n = S_BRAKE;
                  cnt_n   = brake_q - CNT_ONE;
               end else begin
                  state_n = S_DONE;
               end
            end
         endcase
      end

      if (active && abort_eff) begin
         state_n = S_IDLE;
         cnt_n   = '0;
         cyc_n   = '0;
      end
   end

   assign active_n = (state_n == S_DEAD) || (state_n == S_DRV_A) ||
                     (state_n == S_DRV_B) || (state_n == S_BRAKE);

   // Gate outputs are decoded from the next state, so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hlh  <= 1'b0;
         hll  <= 1'b0;
         hrh  <= 1'b0;
         hrl  <= 1'b0;
         txrx <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         hlh  <= (state_n == S_DRV_A);
         hrl  <= (state_n == S_DRV_A) || (state_n == S_BRAKE);
         hrh  <= (state_n == S_DRV_B);
         hll  <= (state_n == S_DRV_B) || (state_n == S_BRAKE);
         txrx <= active_n;
         busy <= active_n;
         done <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_h_bridge_burst.sv
// tb/tb_h_bridge_burst.sv - scoreboard bench for h_bridge_burst
module tb_h_bridge_burst;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] half_period = '0;
   logic [3:0]  dead = '0;
   logic [7:0]  n_cycles = '0;
   logic [15:0] brake_len = '0;
`ifdef HB_ILIMIT_EN
   logic        ilim = 1'b0;
`endif
   logic        hlh, hll, hrh, hrl, txrx, busy, done, fault;

   always #5 clk = ~clk;

   h_bridge_burst #(.CNT_W(16), .CYC_W(8), .DEAD_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef HB_ILIMIT_EN
      .ilim(ilim),
`endif
      .half_period(half_period), .dead(dead), .n_cycles(n_cycles), .brake_len(brake_len),
      .hlh(hlh), .hll(hll), .hrh(hrh), .hrl(hrl),
      .txrx(txrx), .busy(busy), .done(done), .fault(fault)
   );

   // Per-cycle output vector {hlh,hll,hrh,hrl,txrx,busy,done}.
   localparam logic [6:0] V_OFF  = 7'b0000110;
   localparam logic [6:0] V_A    = 7'b1001110;
   localparam logic [6:0] V_B    = 7'b0110110;
   localparam logic [6:0] V_BRK  = 7'b0101110;
   localparam logic [6:0] V_DONE = 7'b0000001;
   localparam logic [6:0] V_IDLE = 7'b0000000;

   int n_checks = 0;
   int n_fail   = 0;
   logic [6:0] exp_q[$];
   logic [6:0] trace[$];
   logic       exp_fault = 1'b0;
   logic [6:0] act_v, exp_v;
   int         mon_cyc = 0;

   // Reference: expected per-cycle outputs from cycle 1 onward, plus one idle cycle.
   task automatic build(input int h, input int d, input int n, input int b);
      int hh;
      hh = (h == 0) ? 1 : h;
      trace = {};
      if (n != 0) begin
         for (int c = 0; c < n; c++) begin
            repeat (d)  trace.push_back(V_OFF);
            repeat (hh) trace.push_back(V_A);
            repeat (d)  trace.push_back(V_OFF);
            repeat (hh) trace.push_back(V_B);
         end
         repeat (d) trace.push_back(V_OFF);
         repeat (b) trace.push_back(V_BRK);
      end
      trace.push_back(V_DONE);
      trace.push_back(V_IDLE);
   endtask

   // Monitor: every cycle compares against the scoreboard head (idle when empty).
   always @(negedge clk) begin
      mon_cyc++;
      act_v = {hlh, hll, hrh, hrl, txrx, busy, done};
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : V_IDLE;
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL outputs t=%0d act=%b exp=%b", mon_cyc, act_v, exp_v);
      end
      n_checks++;
      if (fault !== exp_fault) begin
         n_fail++;
         $display("FAIL fault t=%0d act=%b exp=%b", mon_cyc, fault, exp_fault);
      end
      n_checks++;
      if ((hlh && hll) || (hrh && hrl) || (hlh && hrl && hrh && hll)) begin
         n_fail++;
         $display("FAIL shoot_through t=%0d gates=%b exp=no_overlap", mon_cyc, {hlh, hll, hrh, hrl});
      end
   end

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() > 0 && w < 200) begin
         @(posedge clk);
         w++;
      end
      n_checks++;
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
         exp_q = {};
      end
      @(posedge clk);
   endtask

   // abort_k = 0: no abort; otherwise abort is sampled at the end of burst cycle abort_k.
   task automatic run_burst(input int h, input int d, input int n, input int b,
                            input int abort_k, input bit perturb);
      int len, last, busy_last;
      build(h, d, n, b);
      len = trace.size() - 1;
      if (abort_k > 0) begin
         while (trace.size() > abort_k) void'(trace.pop_back());
         trace.push_back(V_IDLE);
      end
      last      = (abort_k > 0) ? abort_k : len;
      busy_last = (abort_k > 0) ? abort_k : len - 1;
      @(negedge clk);
      half_period = 16'(h);
      dead        = 4'(d);
      n_cycles    = 8'(n);
      brake_len   = 16'(b);
      start       = 1'b1;
      @(posedge clk);
      foreach (trace[i]) exp_q.push_back(trace[i]);
      for (int j = 1; j <= last; j++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (perturb) begin
            half_period = 16'($urandom_range(0, 7));
            dead        = 4'($urandom_range(0, 3));
            n_cycles    = 8'($urandom_range(0, 5));
            brake_len   = 16'($urandom_range(0, 5));
            if (j <= busy_last && n > 0) start = 1'($urandom_range(0, 1));
         end
         if (j == abort_k) abort = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      drain();
   endtask

   initial begin
      int h, d, n, b, k, len;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({hlh, hll, hrh, hrl, txrx, busy, done, fault} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state act=%b exp=00000000", {hlh, hll, hrh, hrl, txrx, busy, done, fault});
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      run_burst(4, 2, 1, 3, 0, 1'b0);
      run_burst(0, 0, 0, 0, 0, 1'b0);
      run_burst(0, 0, 3, 0, 0, 1'b0);
      run_burst(3, 1, 2, 2, 6, 1'b0);
      run_burst(4, 2, 1, 3, 0, 1'b1);

      // abort together with start in idle: nothing starts
      @(negedge clk);
      n_cycles = 8'd2;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);

      for (int t = 0; t < 40; t++) begin
         h = $urandom_range(0, 5);
         d = $urandom_range(0, 3);
         n = $urandom_range(0, 4);
         b = $urandom_range(0, 4);
         k = 0;
         build(h, d, n, b);
         len = trace.size() - 1;
         if (n > 0 && len >= 2 && $urandom_range(0, 3) == 0) k = $urandom_range(1, len - 1);
         run_burst(h, d, n, b, k, 1'($urandom_range(0, 1)));
      end

`ifdef HB_ILIMIT_EN
      // overcurrent during DRV_A: gates off next cycle, fault sticks, start blocked
      build(4, 1, 2, 0);
      @(negedge clk);
      half_period = 16'd4;
      dead        = 4'd1;
      n_cycles    = 8'd2;
      brake_len   = 16'd0;
      start       = 1'b1;
      @(posedge clk);
      exp_q.push_back(trace[0]);
      exp_q.push_back(trace[1]);
      exp_q.push_back(V_IDLE);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      ilim = 1'b1;
      @(posedge clk);
      exp_fault = 1'b1;
      @(negedge clk);
      ilim  = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_fault = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      drain();
      run_burst(1, 1, 1, 1, 0, 1'b0);
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
